// File: rtl/rom_arbiter_if.sv
// Bus bundle between the two ROM requesters, the shared synchronous ROM and
// rom_arbiter.
//   slave  : arbiter side (takes requests and ROM data, drives acks, address, returned data)
//   master : requester/ROM side (drives requests and ROM data, observes arbiter outputs)
// Signals:
//   req0/addr0, req1/addr1 : read requests and addresses per requester
//   ack0/ack1              : one-cycle grant acknowledge per grant
//   rom_addr/rom_dout      : shared ROM address out / registered ROM data in
//   rdata, rvalid0/rvalid1 : returned data and its owner strobe
interface rom_arbiter_if #(
   parameter int ADDRESS_WIDTH = 8,
   parameter int DATA_WIDTH    = 8
);
   logic                     req0;
   logic [ADDRESS_WIDTH-1:0] addr0;
   logic                     req1;
   logic [ADDRESS_WIDTH-1:0] addr1;
   logic                     ack0;
   logic                     ack1;
   logic [ADDRESS_WIDTH-1:0] rom_addr;
   logic [DATA_WIDTH-1:0]    rom_dout;
   logic [DATA_WIDTH-1:0]    rdata;
   logic                     rvalid0;
   logic                     rvalid1;

   modport slave (
      input  req0, addr0, req1, addr1, rom_dout,
      output ack0, ack1, rom_addr, rdata, rvalid0, rvalid1
   );

   modport master (
      output req0, addr0, req1, addr1, rom_dout,
      input  ack0, ack1, rom_addr, rdata, rvalid0, rvalid1
   );
endinterface

// File: rtl/rom_arbiter.sv
// Two-requester round-robin arbiter in front of a shared synchronous ROM
// (one-cycle registered read). One grant per clock at most; the granted
// address is registered onto rom_addr and acked for one cycle. An owner tag
// follows the read through two pipeline stages so the returned data is
// presented on rdata with the matching rvalid three edges after the grant.
// Ports:
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : rom_arbiter_if slave modport (requests, ROM port, returned data)
module rom_arbiter #(
   parameter int ADDRESS_WIDTH = 8,
   parameter int DATA_WIDTH    = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   rom_arbiter_if.slave bus
);

   typedef enum logic {
      GRANT0 = 1'b0,
      GRANT1 = 1'b1
   } owner_t;

   owner_t     last_grant;
   logic       grant0;
   logic       grant1;
   // tag_s1[i]: read issued to ROM this cycle belongs to requester i
   // tag_s2[i]: rom_dout this cycle belongs to requester i
   logic [1:0] tag_s1;
   logic [1:0] tag_s2;

   // A tie goes to the requester that did not win most recently.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (bus.req0 && bus.req1) begin
         grant0 = (last_grant == GRANT1);
         grant1 = (last_grant == GRANT0);
      end else begin
         grant0 = bus.req0;
         grant1 = bus.req1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant   <= GRANT1;
         bus.ack0     <= 1'b0;
         bus.ack1     <= 1'b0;
         bus.rom_addr <= '0;
         tag_s1       <= '0;
         tag_s2       <= '0;
         bus.rdata    <= '0;
         bus.rvalid0  <= 1'b0;
         bus.rvalid1  <= 1'b0;
      end else begin
         bus.ack0 <= grant0;
         bus.ack1 <= grant1;
         if (grant0) begin
            bus.rom_addr <= bus.addr0;
            last_grant   <= GRANT0;
         end else if (grant1) begin
            bus.rom_addr <= bus.addr1;
            last_grant   <= GRANT1;
         end
         tag_s1      <= {grant1, grant0};
         tag_s2      <= tag_s1;
         bus.rvalid0 <= tag_s2[0];
         bus.rvalid1 <= tag_s2[1];
         if (|tag_s2) begin
            bus.rdata <= bus.rom_dout;
         end
      end
   end

endmodule

// File: tb/tb_rom_arbiter.sv
// Scoreboard bench for rom_arbiter: directed request vectors carry a
// hand-computed expected grant; each grant pushes an expected ack and an
// expected read return, and a monitor pops and compares them as the DUT
// presents ack/rvalid, including the cycle at which each must appear.
module tb_rom_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   cyc_n  = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc_n <= cyc_n + 1;

   rom_arbiter_if #(.ADDRESS_WIDTH(8), .DATA_WIDTH(8)) bus ();

   rom_arbiter #(.ADDRESS_WIDTH(8), .DATA_WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   function automatic logic [7:0] rom_val(input logic [7:0] a);
      return 8'(a * 8'd3 + 8'h17);
   endfunction

   // Synchronous ROM: one-cycle registered read.
   always @(posedge clk) bus.rom_dout <= rom_val(bus.rom_addr);

   typedef struct {
      int         id;
      logic [7:0] val;
      int         due;
   } exp_t;

   exp_t ack_q[$];
   exp_t rd_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Monitor: pops expectations whenever the DUT presents ack or rvalid.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (bus.ack0 || bus.ack1) begin
            if (ack_q.size() == 0) begin
               chk("ack_unexpected", {bus.ack1, bus.ack0}, 2'b00);
            end else begin
               e = ack_q.pop_front();
               chk("ack_owner", {bus.ack1, bus.ack0}, (e.id == 1) ? 2'b10 : 2'b01);
               chk("ack_rom_addr", bus.rom_addr, e.val);
               chk("ack_cycle", cyc_n, e.due);
            end
         end
         if (bus.rvalid0 || bus.rvalid1) begin
            if (rd_q.size() == 0) begin
               chk("rvalid_unexpected", {bus.rvalid1, bus.rvalid0}, 2'b00);
            end else begin
               e = rd_q.pop_front();
               chk("rvalid_owner", {bus.rvalid1, bus.rvalid0}, (e.id == 1) ? 2'b10 : 2'b01);
               chk("rdata", bus.rdata, e.val);
               chk("rvalid_cycle", cyc_n, e.due);
            end
         end
      end
   end

   // Apply one vector for one rising edge; g is the hand-computed grant
   // (0, 1, or 2 for none).
   task automatic cyc(input logic r0, input logic [7:0] a0,
                      input logic r1, input logic [7:0] a1, input int g);
      logic [7:0] a;
      bus.req0  = r0;
      bus.addr0 = a0;
      bus.req1  = r1;
      bus.addr1 = a1;
      if (g != 2) begin
         a = (g == 0) ? a0 : a1;
         ack_q.push_back('{g, a, cyc_n + 1});
         rd_q.push_back('{g, rom_val(a), cyc_n + 3});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, 8'h00, 2);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_acks"}, {bus.ack1, bus.ack0}, 2'b00);
      chk({tag, "_rvalids"}, {bus.rvalid1, bus.rvalid0}, 2'b00);
      chk({tag, "_rom_addr"}, bus.rom_addr, 8'h00);
      chk({tag, "_rdata"}, bus.rdata, 8'h00);
   endtask

   initial begin
      bus.req0 = 1'b0; bus.addr0 = '0;
      bus.req1 = 1'b0; bus.addr1 = '0;
      #1;
      chk_all_zero("reset");
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;

      // Both requesting from the first edge after reset: 0,1,0,1.
      for (int i = 0; i < 4; i++) cyc(1'b1, 8'h00, 1'b1, 8'h40, i % 2);
      idle(4);

      // Single read by requester 0.
      cyc(1'b1, 8'h10, 1'b0, 8'h00, 0);
      idle(4);

      // Requester 1 streaming across the address wrap.
      cyc(1'b0, 8'h00, 1'b1, 8'hFE, 1);
      cyc(1'b0, 8'h00, 1'b1, 8'hFF, 1);
      cyc(1'b0, 8'h00, 1'b1, 8'h00, 1);
      idle(4);

      // Read of 0x33 then idle: address and data hold.
      cyc(1'b1, 8'h33, 1'b0, 8'h00, 0);
      idle(5);
      chk("idle_rom_addr", bus.rom_addr, 8'h33);
      chk("idle_rdata", bus.rdata, rom_val(8'h33));
      chk("idle_acks", {bus.ack1, bus.ack0}, 2'b00);
      chk("idle_rvalids", {bus.rvalid1, bus.rvalid0}, 2'b00);

      // Idle cycles leave last_grant at 0, so the next tie goes to 1.
      cyc(1'b1, 8'h01, 1'b1, 8'h02, 1);
      cyc(1'b1, 8'h01, 1'b0, 8'h02, 0);
      idle(4);

      // Reset with a read in flight: outputs clear at once, read discarded.
      cyc(1'b1, 8'h20, 1'b0, 8'h00, 0);
      chk("pre_reset_ack0", bus.ack0, 1'b1);
      bus.req0 = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk_all_zero("async_reset");
      ack_q.delete();
      rd_q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle(4);
      cyc(1'b1, 8'h05, 1'b1, 8'h06, 0);
      cyc(1'b0, 8'h05, 1'b1, 8'h06, 1);
      idle(4);

      chk("ack_queue_drained", ack_q.size(), 0);
      chk("rd_queue_drained", rd_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
